// File: rtl/divider_pkg.sv
// Shared types for the sequential restoring divider.
// Build option: DIVIDER_SIGNED_EN selects two's-complement operands.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int DIV_WID_DEF = 32;

    function automatic int cnt_wid(input int wid);
        return (wid > 1) ? $clog2(wid) : 1;
    endfunction

endpackage

// File: rtl/divider_step.sv
// One radix-2 restoring iteration: shift in a dividend bit, trial subtract,
// keep the difference when it did not go negative.
module divider_step #(
    parameter int DIVISOR_WID = 32
) (
    input  logic [DIVISOR_WID:0]   prem_i,
    input  logic                   bit_i,
    input  logic [DIVISOR_WID-1:0] divisor_i,
    output logic [DIVISOR_WID:0]   prem_o,
    output logic                   qbit_o
);

    logic [DIVISOR_WID+1:0] shifted;
    logic [DIVISOR_WID+1:0] trial;

    always_comb begin
        shifted = {prem_i, bit_i};
        trial   = shifted - {2'b00, divisor_i};
        qbit_o  = ~trial[DIVISOR_WID+1];
        prem_o  = qbit_o ? trial[DIVISOR_WID:0] : shifted[DIVISOR_WID:0];
    end

endmodule

// File: rtl/divider_seq.sv
// Sequential restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define DIVIDER_SIGNED_EN for two's-complement operands (sign fix on the final load).
module divider_seq
    import divider_pkg::*;
#(
    parameter int DIVIDEND_WID = DIV_WID_DEF,
    parameter int DIVISOR_WID  = DIV_WID_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DIVIDEND_WID-1:0] dividend,
    input  logic [DIVISOR_WID-1:0]  divisor,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DIVIDEND_WID-1:0] quotient,
    output logic [DIVISOR_WID-1:0]  remainder,
    output logic                    div_by_zero
);

    localparam int CNT_W = cnt_wid(DIVIDEND_WID);

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [DIVIDEND_WID-1:0] dvd_q;
    logic [DIVISOR_WID-1:0]  dvs_q;
    logic [DIVISOR_WID:0]    prem_q;
    logic [DIVISOR_WID:0]    prem_d;
    logic [DIVIDEND_WID-1:0] quo_q;
    logic [DIVIDEND_WID-1:0] quo_d;
    logic                    qbit;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic [DIVIDEND_WID-1:0] quotient_q;
    logic [DIVISOR_WID-1:0]  remainder_q;
    logic                    dbz_q;
    logic [DIVIDEND_WID-1:0] dvd_in;
    logic [DIVISOR_WID-1:0]  dvs_in;
    logic [DIVIDEND_WID-1:0] res_q_d;
    logic [DIVISOR_WID-1:0]  res_r_d;

    divider_step #(
        .DIVISOR_WID(DIVISOR_WID)
    ) u_step (
        .prem_i   (prem_q),
        .bit_i    (dvd_q[cnt_q]),
        .divisor_i(dvs_q),
        .prem_o   (prem_d),
        .qbit_o   (qbit)
    );

    always_comb begin
        quo_d        = quo_q;
        quo_d[cnt_q] = qbit;
    end

`ifdef DIVIDER_SIGNED_EN
    logic neg_q_q;
    logic neg_r_q;

    // Magnitudes are divided; the most-negative value maps onto itself as unsigned.
    always_comb begin
        dvd_in  = dividend[DIVIDEND_WID-1] ? -dividend : dividend;
        dvs_in  = divisor[DIVISOR_WID-1] ? -divisor : divisor;
        res_q_d = neg_q_q ? -quo_d : quo_d;
        res_r_d = neg_r_q ? -prem_d[DIVISOR_WID-1:0] : prem_d[DIVISOR_WID-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else if (state_q == IDLE && in_valid) begin
            neg_q_q <= dividend[DIVIDEND_WID-1] ^ divisor[DIVISOR_WID-1];
            neg_r_q <= dividend[DIVIDEND_WID-1];
        end
    end
`else
    always_comb begin
        dvd_in  = dividend;
        dvs_in  = divisor;
        res_q_d = quo_d;
        res_r_d = prem_d[DIVISOR_WID-1:0];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            prem_q      <= '0;
            quo_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        dvd_q      <= dvd_in;
                        dvs_q      <= dvs_in;
                        if (divisor == '0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= DIVISOR_WID'(dividend);
                            dbz_q       <= 1'b1;
                        end else begin
                            state_q <= CALC;
                            cnt_q   <= CNT_W'(DIVIDEND_WID - 1);
                            prem_q  <= '0;
                            quo_q   <= '0;
                        end
                    end
                end
                CALC: begin
                    prem_q <= prem_d;
                    quo_q  <= quo_d;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        quotient_q  <= res_q_d;
                        remainder_q <= res_r_d;
                        dbz_q       <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
